// File: rtl/picture_buffer_pp_pkg.sv
// Shared types and helpers for the ping-pong picture buffer.
// Holds the FSM state type, default geometry and counter-width helper.
package pb_pkg;

    typedef enum logic [0:0] {
        FILL,
        FULL_WAIT
    } pb_state_t;

    localparam int DEF_DW = 10;
    localparam int DEF_CH = 3;
    localparam int DEF_W  = 16;
    localparam int DEF_H  = 16;

    // Counter width for a range of n positions, never below one bit.
    function automatic int pb_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/picture_buffer_pp_if.sv
// Pixel-stream / consumer bundle for the ping-pong picture buffer.
// master: camera + consumer side; slave: the buffer itself.
interface picture_buffer_pp_if #(
    parameter int DW = 10,
    parameter int CH = 3,
    parameter int W  = 16,
    parameter int H  = 16,
    parameter int CW = 8
);
    logic [DW-1:0] i_pix [CH];
    logic          i_take;
    logic          i_sof;
    logic          i_fetch;
    logic          o_oktofetch;
    logic [DW-1:0] o_buf [CH][H][W];
    logic [CW-1:0] o_drop_cnt;

    modport master (
        output i_pix, i_take, i_sof, i_fetch,
        input  o_oktofetch, o_buf, o_drop_cnt
    );

    modport slave (
        input  i_pix, i_take, i_sof, i_fetch,
        output o_oktofetch, o_buf, o_drop_cnt
    );
endinterface

// File: rtl/picture_buffer_pp_raster_cnt.sv
// Raster (x,y) position counter with row and frame wrap.
// Ports: i_clk, i_rst, inc (advance), clr (restart at 0,0), x, y, last.
module pb_raster_cnt
    import pb_pkg::*;
#(
    parameter int W = 16,
    parameter int H = 16,
    localparam int XW = pb_cw(W),
    localparam int YW = pb_cw(H)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          inc,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] bx;
    logic [YW-1:0] by;

    // clr and inc together means "this sample sits at (0,0)",
    // so the advance is applied on top of the cleared position.
    always_comb begin
        bx   = clr ? '0 : x;
        by   = clr ? '0 : y;
        last = (x == XW'(W - 1)) && (y == YW'(H - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (bx == XW'(W - 1)) begin
                x <= '0;
                y <= (by == YW'(H - 1)) ? '0 : by + 1'b1;
            end else begin
                x <= bx + 1'b1;
                y <= by;
            end
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end
    end

endmodule

// File: rtl/picture_buffer_pp.sv
// Double-buffered W x H x CH picture capture with sof resync and overflow policy.
// Ports: i_clk, i_rst (sync, active-high), bus (slave: pixels in, frame/drop count out).
module picture_buffer_pp
    import pb_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CH   = DEF_CH,
    parameter int W    = DEF_W,
    parameter int H    = DEF_H,
    parameter int MODE = 0,
    parameter int CW   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    picture_buffer_pp_if.slave  bus
);

    localparam int XW = pb_cw(W);
    localparam int YW = pb_cw(H);

    pb_state_t     state, state_n;
    logic          wr_sel, wr_sel_n;
    logic          rd_valid, rd_valid_n;
    logic [CW-1:0] drop_cnt;
    logic          drop_inc;
    logic          cnt_inc, cnt_clr, we;
    logic          rel, at_last;
    logic [XW-1:0] x, wx;
    logic [YW-1:0] y, wy;
    logic          last;
    logic          rd_sel;

    logic [DW-1:0] bank [2][CH][H][W];

    pb_raster_cnt #(
        .W (W),
        .H (H)
    ) u_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    // A sof sample is always written at (0,0) regardless of the counter.
    always_comb begin
        wx      = bus.i_sof ? '0 : x;
        wy      = bus.i_sof ? '0 : y;
        at_last = bus.i_sof ? ((W == 1) && (H == 1)) : last;
        rel     = bus.i_fetch & rd_valid;
    end

    always_comb begin
        state_n    = state;
        wr_sel_n   = wr_sel;
        rd_valid_n = rd_valid;
        drop_inc   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        we         = 1'b0;
        unique case (state)
            FILL: begin
                cnt_inc = bus.i_take;
                cnt_clr = bus.i_sof;
                we      = bus.i_take;
                if (bus.i_sof && ((x != '0) || (y != '0)))
                    drop_inc = 1'b1;
                if (rel)
                    rd_valid_n = 1'b0;
                // Swap overrides the release so the consumer sees no gap.
                if (bus.i_take && at_last) begin
                    if (!rd_valid || rel) begin
                        wr_sel_n   = ~wr_sel;
                        rd_valid_n = 1'b1;
                    end else if (MODE == 0) begin
                        state_n = FULL_WAIT;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            FULL_WAIT: begin
                if (rel) begin
                    wr_sel_n = ~wr_sel;
                    state_n  = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= FILL;
            wr_sel   <= 1'b0;
            rd_valid <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_n;
            wr_sel   <= wr_sel_n;
            rd_valid <= rd_valid_n;
            if (drop_inc && (drop_cnt != {CW{1'b1}}))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Bank storage is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (we && !i_rst) begin
            for (int c = 0; c < CH; c++)
                bank[wr_sel][c][wy][wx] <= bus.i_pix[c];
        end
    end

    assign rd_sel = ~wr_sel;

    // Writes only ever target the other bank, so this view is stable
    // for as long as o_oktofetch is high.
    always_comb begin
        for (int c = 0; c < CH; c++)
            for (int h = 0; h < H; h++)
                for (int w = 0; w < W; w++)
                    bus.o_buf[c][h][w] = bank[rd_sel][c][h][w];
    end

    assign bus.o_oktofetch = rd_valid;
    assign bus.o_drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_picture_buffer_pp.sv
// Scoreboard bench for picture_buffer_pp: MODE=0 (CW=8) and MODE=1 (CW=2) instances.
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares.
module tb_picture_buffer_pp;

    localparam int K_OK   = 0;
    localparam int K_DROP = 1;
    localparam int K_PIX  = 2;

    typedef struct {
        int cyc;
        int d;
        int kind;
        int c;
        int y;
        int x;
        int exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    picture_buffer_pp_if #(.DW(10), .CH(3), .W(16), .H(16), .CW(8)) b0 ();
    picture_buffer_pp_if #(.DW(10), .CH(3), .W(16), .H(16), .CW(2)) b1 ();

    picture_buffer_pp #(
        .DW(10), .CH(3), .W(16), .H(16), .MODE(0), .CW(8)
    ) d0 (
        .i_clk (clk),
        .i_rst (rst0),
        .bus   (b0)
    );

    picture_buffer_pp #(
        .DW(10), .CH(3), .W(16), .H(16), .MODE(1), .CW(2)
    ) d1 (
        .i_clk (clk),
        .i_rst (rst1),
        .bus   (b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int get(input int d, input int kind,
                               input int c, input int y, input int x);
        if (d == 0) begin
            if (kind == K_OK)   return int'(b0.o_oktofetch);
            if (kind == K_DROP) return int'(b0.o_drop_cnt);
            return int'(b0.o_buf[c][y][x]);
        end
        if (kind == K_OK)   return int'(b1.o_oktofetch);
        if (kind == K_DROP) return int'(b1.o_drop_cnt);
        return int'(b1.o_buf[c][y][x]);
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t  e;
            int    got;
            string nm;
            e   = sb.pop_front();
            got = get(e.d, e.kind, e.c, e.y, e.x);
            nm  = (e.kind == K_OK) ? "oktofetch" :
                  (e.kind == K_DROP) ? "drop_cnt" : "pix";
            checks++;
            if (got != e.exp) begin
                errors++;
                $display("FAIL %s dut%0d cyc%0d [%0d][%0d][%0d]: got %0d want %0d",
                         nm, e.d, cyc, e.c, e.y, e.x, got, e.exp);
            end
        end
    end

    task automatic push(input int d, input int kind, input int c,
                        input int y, input int x, input int v);
        exp_t e;
        e.cyc = cyc; e.d = d; e.kind = kind;
        e.c = c; e.y = y; e.x = x; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic tk, input logic sf,
                         input logic fc, input int n);
        if (d == 0) begin
            b0.i_take = tk; b0.i_sof = sf; b0.i_fetch = fc;
            for (int c = 0; c < 3; c++) b0.i_pix[c] = 10'(n + c);
        end else begin
            b1.i_take = tk; b1.i_sof = sf; b1.i_fetch = fc;
            for (int c = 0; c < 3; c++) b1.i_pix[c] = 10'(n + c);
        end
    endtask

    // cnt takes with pixel base+k; okv >= 0 checks o_oktofetch mid-frame.
    task automatic takes(input int d, input int base, input int cnt,
                         input bit sof1, input bit fetch_last, input int okv);
        for (int k = 0; k < cnt; k++) begin
            drive(d, 1'b1, sof1 && (k == 0), fetch_last && (k == cnt - 1), base + k);
            tick();
            if (okv >= 0 && k < cnt - 1) push(d, K_OK, 0, 0, 0, okv);
        end
        drive(d, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic fetch(input int d);
        drive(d, 1'b0, 1'b0, 1'b1, 0);
        tick();
        drive(d, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic frame_is(input int d, input int base);
        push(d, K_OK, 0, 0, 0, 1);
        push(d, K_PIX, 0, 0, 0, base);
        push(d, K_PIX, 1, 0, 1, base + 2);
        push(d, K_PIX, 2, 15, 15, base + 257);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 1'b0, 0);
        tick();
        tick();
        push(0, K_OK, 0, 0, 0, 0);
        push(0, K_DROP, 0, 0, 0, 0);
        push(1, K_OK, 0, 0, 0, 0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();

        // MODE=0: first frame, then overflow into FULL_WAIT
        takes(0, 1, 256, 1, 0, 0);
        frame_is(0, 1);
        takes(0, 300, 256, 1, 0, 1);
        frame_is(0, 1);
        takes(0, 600, 256, 1, 0, 1);
        push(0, K_DROP, 0, 0, 0, 0);
        frame_is(0, 1);
        fetch(0);
        frame_is(0, 300);
        fetch(0);
        push(0, K_OK, 0, 0, 0, 0);

        // sof at pixel 100 aborts and restarts the frame
        takes(0, 0, 100, 0, 0, 0);
        push(0, K_DROP, 0, 0, 0, 0);
        takes(0, 700, 1, 1, 0, -1);
        push(0, K_DROP, 0, 0, 0, 1);
        push(0, K_OK, 0, 0, 0, 0);
        takes(0, 701, 254, 0, 0, 0);
        push(0, K_OK, 0, 0, 0, 0);
        takes(0, 955, 1, 0, 0, -1);
        frame_is(0, 700);

        // last pixel and release on the same edge
        takes(0, 10, 256, 1, 1, 1);
        frame_is(0, 10);
        push(0, K_DROP, 0, 0, 0, 1);
        tick();
        push(0, K_OK, 0, 0, 0, 1);

        // reset mid-frame
        takes(0, 20, 50, 1, 0, 1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        push(0, K_OK, 0, 0, 0, 0);
        push(0, K_DROP, 0, 0, 0, 0);
        takes(0, 30, 256, 1, 0, 0);
        frame_is(0, 30);

        // MODE=1 with a 2-bit saturating drop counter
        takes(1, 1, 256, 1, 0, 0);
        frame_is(1, 1);
        takes(1, 300, 256, 1, 0, 1);
        push(1, K_DROP, 0, 0, 0, 1);
        takes(1, 400, 256, 1, 0, 1);
        push(1, K_DROP, 0, 0, 0, 2);
        frame_is(1, 1);
        takes(1, 500, 256, 1, 0, 1);
        push(1, K_DROP, 0, 0, 0, 3);
        takes(1, 600, 256, 1, 0, 1);
        push(1, K_DROP, 0, 0, 0, 3);
        frame_is(1, 1);
        fetch(1);
        push(1, K_OK, 0, 0, 0, 0);
        takes(1, 700, 256, 1, 0, 0);
        frame_is(1, 700);

        tick();
        tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
